pipe_if_bp: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage pipeline, successor to the fixed PC+4/branch/jump fetch stage. Holds the fetch PC, drives the instruction-memory word address, and predicts taken control transfers through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. A single redirect port from execute replaces the old branch/jump select mux. A single update port trains the BTB with resolved outcomes.

---
 rtl/pipe_if_bp_pkg.sv | 30 +++
 rtl/pipe_if_bp_if.sv | 37 +++
 rtl/pipe_if_bp_btb_dm.sv | 65 ++++++
 rtl/pipe_if_bp.sv | 74 +++++++
 tb/tb_pipe_if_bp.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipe_if_bp_pkg.sv
// Shared fetch-stage definitions: BTB counter encodings,
// saturating counter helpers and the default reset PC.
package pipe_if_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    function automatic cnt_e sat_inc(input cnt_e c);
        case (c)
            SNT:     sat_inc = WNT;
            WNT:     sat_inc = WT;
            default: sat_inc = ST;
        endcase
    endfunction

    function automatic cnt_e sat_dec(input cnt_e c);
        case (c)
            ST:      sat_dec = WT;
            WT:      sat_dec = WNT;
            default: sat_dec = SNT;
        endcase
    endfunction

endpackage

// File: rtl/pipe_if_bp_if.sv
// Fetch-stage bundle: downstream control, BTB training,
// instruction memory and fetch outputs.
interface pipe_if_bp_if;
    import pipe_if_bp_pkg::*;

    logic        in_stall;
    logic        in_redirect;
    logic [31:0] in_redirect_addr;
    logic        in_upd_valid;
    logic [31:0] in_upd_pc;
    logic [31:0] in_upd_target;
    logic        in_upd_taken;
    logic [31:0] in_imem_rdata;
    logic [29:0] out_imem_addr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [31:0] out_instruction;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;

    modport master (
        output in_stall, in_redirect, in_redirect_addr,
        output in_upd_valid, in_upd_pc, in_upd_target,
        output in_upd_taken, in_imem_rdata,
        input  out_imem_addr, out_pc, out_npc,
        input  out_instruction, out_pred_taken, out_pred_target
    );

    modport slave (
        input  in_stall, in_redirect, in_redirect_addr,
        input  in_upd_valid, in_upd_pc, in_upd_target,
        input  in_upd_taken, in_imem_rdata,
        output out_imem_addr, out_pc, out_npc,
        output out_instruction, out_pred_taken, out_pred_target
    );

endinterface

// File: rtl/pipe_if_bp_btb_dm.sv
// Direct-mapped branch target buffer with 2-bit counters,
// one combinational lookup port and one training port.
module btb_dm
    import pipe_if_bp_pkg::*;
#(
    parameter int          IDX_W     = 4,
    parameter logic [1:0]  ALLOC_CNT = 2'b10,
    localparam int         TAG_W     = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic             taken,
    output logic [31:0]      target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic             wr_taken
);

    localparam int N = 2 ** IDX_W;

    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [31:0]      target_q [N];
    cnt_e             cnt_q    [N];

    logic wr_hit;

    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign taken  = cnt_q[rd_idx][1];
    assign target = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= SNT;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                if (wr_taken) begin
                    cnt_q[wr_idx]    <= sat_inc(cnt_q[wr_idx]);
                    target_q[wr_idx] <= wr_target;
                end else begin
                    cnt_q[wr_idx] <= sat_dec(cnt_q[wr_idx]);
                end
            end else if (wr_taken) begin
                // A taken miss evicts whatever aliases this slot.
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
                cnt_q[wr_idx]    <= cnt_e'(ALLOC_CNT);
            end
        end
    end

endmodule

// File: rtl/pipe_if_bp.sv
// Instruction-fetch stage: PC register, next-PC selection
// and BTB-driven zero-bubble taken prediction.
module pipe_if_bp
    import pipe_if_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BTB_IDX_W = 4,
    parameter logic [1:0]  ALLOC_CNT = 2'b10
) (
    input logic         in_clk,
    input logic         in_rst,
    pipe_if_bp_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] npc;
    logic [31:0] next_pc;
    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        pred_taken;
    logic        unused;

    assign npc        = pc_q + 32'd4;
    assign pred_taken = btb_hit && btb_taken;

    assign bus.out_pc          = pc_q;
    assign bus.out_npc         = npc;
    assign bus.out_imem_addr   = pc_q[31:2];
    assign bus.out_instruction = bus.in_imem_rdata;
    assign bus.out_pred_taken  = pred_taken;
    assign bus.out_pred_target = pred_taken ? btb_target : 32'd0;

    assign unused = ^{bus.in_redirect_addr[1:0], bus.in_upd_pc[1:0]};

    btb_dm #(
        .IDX_W     (BTB_IDX_W),
        .ALLOC_CNT (ALLOC_CNT)
    ) u_btb (
        .clk       (in_clk),
        .rst       (in_rst),
        .rd_idx    (pc_q[BTB_IDX_W+1:2]),
        .rd_tag    (pc_q[31:BTB_IDX_W+2]),
        .hit       (btb_hit),
        .taken     (btb_taken),
        .target    (btb_target),
        .wr_en     (bus.in_upd_valid),
        .wr_idx    (bus.in_upd_pc[BTB_IDX_W+1:2]),
        .wr_tag    (bus.in_upd_pc[31:BTB_IDX_W+2]),
        .wr_target (bus.in_upd_target),
        .wr_taken  (bus.in_upd_taken)
    );

    // Redirect outranks stall so an execute redirect is never dropped.
    always_comb begin
        next_pc = npc;
        if (bus.in_redirect) begin
            next_pc = {bus.in_redirect_addr[31:2], 2'b00};
        end else if (bus.in_stall) begin
            next_pc = pc_q;
        end else if (pred_taken) begin
            next_pc = {btb_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

endmodule

// File: tb/tb_pipe_if_bp.sv
// Directed bench for pipe_if_bp: reset, stall, redirect,
// BTB training, saturation, aliasing and wrap-around.
module tb_pipe_if_bp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    localparam logic [31:0] IMEM_KEY = 32'hDEAD_BEEF;

    pipe_if_bp_if bus ();

    pipe_if_bp #(
        .RESET_PC  (32'h0000_0000),
        .BTB_IDX_W (4),
        .ALLOC_CNT (2'b10)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always_comb bus.in_imem_rdata = bus.out_pc ^ IMEM_KEY;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk);
        bus.in_upd_valid  = v;
        bus.in_upd_pc     = pc;
        bus.in_upd_target = tgt;
        bus.in_upd_taken  = tk;
    endtask

    task automatic redir(input logic r, input logic [31:0] a);
        bus.in_redirect      = r;
        bus.in_redirect_addr = a;
    endtask

    initial begin
        bus.in_stall = 1'b0;
        redir(1'b1, 32'h0000_0200);
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_npc", bus.out_npc, 32'h4);
        check("rst_addr", {2'b00, bus.out_imem_addr}, 32'h0);
        check("rst_pt", {31'd0, bus.out_pred_taken}, 32'd0);
        check("rst_ptgt", bus.out_pred_target, 32'h0);

        rst = 1'b0;
        redir(1'b0, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check("seq_4", bus.out_pc, 32'h4);
        tick();
        check("seq_8", bus.out_pc, 32'h8);
        check("instr", bus.out_instruction, 32'h8 ^ IMEM_KEY);

        bus.in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", bus.out_pc, 32'h8);
        end
        redir(1'b1, 32'h0000_0103);
        tick();
        check("redir_stall", bus.out_pc, 32'h100);

        bus.in_stall = 1'b0;
        redir(1'b1, 32'h10);
        tick();
        check("empty_pc", bus.out_pc, 32'h10);
        check("empty_pt", {31'd0, bus.out_pred_taken}, 32'd0);
        redir(1'b0, 32'h0);
        tick();
        check("empty_seq", bus.out_pc, 32'h14);

        upd(1'b1, 32'h10, 32'h40, 1'b1);
        tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b1, 32'h10);
        tick();
        check("train_pt", {31'd0, bus.out_pred_taken}, 32'd1);
        check("train_tgt", bus.out_pred_target, 32'h40);
        redir(1'b0, 32'h0);
        tick();
        check("pred_jump", bus.out_pc, 32'h40);

        upd(1'b1, 32'h10, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        upd(1'b1, 32'h10, 32'h40, 1'b0);
        redir(1'b1, 32'h10);
        tick();
        check("st_to_wt", {31'd0, bus.out_pred_taken}, 32'd1);
        tick();
        check("wt_to_wnt", {31'd0, bus.out_pred_taken}, 32'd0);
        check("wnt_tgt", bus.out_pred_target, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b0, 32'h0);
        tick();
        check("wnt_seq", bus.out_pc, 32'h14);

        upd(1'b1, 32'h10, 32'h40, 1'b1);
        tick();
        upd(1'b1, 32'h50, 32'h80, 1'b1);
        tick();
        upd(1'b1, 32'h90, 32'hF0, 1'b0);
        tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b1, 32'h10);
        tick();
        check("alias_old", {31'd0, bus.out_pred_taken}, 32'd0);
        redir(1'b1, 32'h50);
        tick();
        check("alias_new", {31'd0, bus.out_pred_taken}, 32'd1);
        check("alias_tgt", bus.out_pred_target, 32'h80);

        redir(1'b1, 32'hFFFF_FFFF);
        tick();
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_npc", bus.out_npc, 32'h0);
        check("wrap_addr", {2'b00, bus.out_imem_addr}, 32'h3FFF_FFFF);
        redir(1'b0, 32'h0);
        tick();
        check("wrap_seq", bus.out_pc, 32'h0);

        redir(1'b1, 32'h50);
        tick();
        redir(1'b0, 32'h0);
        bus.in_stall = 1'b1;
        upd(1'b1, 32'h50, 32'hC0, 1'b1);
        #1;
        check("same_old", bus.out_pred_target, 32'h80);
        tick();
        check("same_hold", bus.out_pc, 32'h50);
        check("same_new", bus.out_pred_target, 32'hC0);
        bus.in_stall = 1'b0;
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check("same_jump", bus.out_pc, 32'hC0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
